// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared types and address-split helpers for the direct-mapped data cache.
// Addresses inside the cache are 30-bit word addresses (byte address >> 2),
// split from the top as {tag, index, word offset}.
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int WORD_ADDR_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL_REQ,
    ST_REFILL_DATA,
    ST_WRITE_REQ
  } state_t;

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int sets, input int line_words);
    return WORD_ADDR_W - index_bits(sets) - offset_bits(line_words);
  endfunction

endpackage

// File: rtl/cache_array.sv
// ---------------------------------------------------------------------------
// cache_array
// Tag, valid and data storage for a direct-mapped cache.
//   clk, reset          clock, asynchronous active-low reset (clears valids)
//   rd_index/rd_offset  combinational read port: valid, tag and one word
//   wr_en/wr_index/     word write with per-byte mask
//   wr_offset/wr_mask/
//   wr_data
//   fill_en/fill_tag    writes the tag of line wr_index and marks it valid
// ---------------------------------------------------------------------------
module cache_array
  import cache_pkg::*;
#(
  parameter int  SETS       = 64,
  parameter int  LINE_WORDS = 4,
  localparam int OFF_W      = offset_bits(LINE_WORDS),
  localparam int IDX_W      = index_bits(SETS),
  localparam int TAG_W      = tag_bits(SETS, LINE_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [3:0]       wr_mask,
  input  logic [31:0]      wr_data,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS*LINE_WORDS];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // its inputs from before the edge; = here would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data RAMs are not reset -- only the valid bits are, which
  // is enough to make stale contents unreachable and keeps them mappable to
  // RAM macros.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[wr_index] <= fill_tag;
    end
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          data_mem[{wr_index, wr_offset}][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-through, no-write-allocate cache in front of a shared
// main-memory request/response port.
//   clk, reset        clock, asynchronous active-low reset
//   cpu_addr          byte address from the core (bits [1:0] unused)
//   cpu_re, cpu_we    read request / byte write enables (write wins)
//   cpu_din, cpu_dout write data / read data (valid when stall is low)
//   stall             core must hold; new requests are ignored while high
//   mem_req_*         memory request (line read or masked word write)
//   mem_resp_*        refill beats, LINE_WORDS per line read
// ---------------------------------------------------------------------------
module data_cache
  import cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int OFF_W = offset_bits(LINE_WORDS);
  localparam int IDX_W = index_bits(SETS);
  localparam int TAG_W = tag_bits(SETS, LINE_WORDS);

  state_t state, state_next;

  // Latched request
  logic             pend;
  logic             req_write;
  logic [29:0]      req_addr;
  logic [31:0]      req_data;
  logic [3:0]       req_mask;
  logic [OFF_W-1:0] beat_cnt;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [OFF_W-1:0] req_offset;

  logic             arr_valid;
  logic [TAG_W-1:0] arr_tag;
  logic [31:0]      arr_data;

  logic hit, idle_pend, read_hit, write_hit, accept;
  logic refill_beat, last_beat;
  logic unused_byte_bits;

  assign unused_byte_bits = ^cpu_addr[1:0];

  assign req_tag    = req_addr[29 -: TAG_W];
  assign req_index  = req_addr[OFF_W +: IDX_W];
  assign req_offset = req_addr[OFF_W-1:0];

  assign hit         = arr_valid && (arr_tag == req_tag);
  assign idle_pend   = (state == ST_IDLE) && pend;
  assign read_hit    = idle_pend && !req_write && hit;
  assign write_hit   = idle_pend && req_write && hit;
  assign accept      = !stall && (cpu_re || (cpu_we != 4'b0000));
  assign refill_beat = (state == ST_REFILL_DATA) && mem_resp_valid;
  assign last_beat   = (beat_cnt == OFF_W'(LINE_WORDS - 1));

  // The array is always addressed by the latched request: refill beats and
  // write-hit merges both land in the line of the pending request.
  cache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (req_index),
    .rd_offset (req_offset),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_data   (arr_data),
    .wr_en     (refill_beat || write_hit),
    .wr_index  (req_index),
    .wr_offset (refill_beat ? beat_cnt : req_offset),
    .wr_mask   (refill_beat ? 4'hF : req_mask),
    .wr_data   (refill_beat ? mem_resp_data : req_data),
    .fill_en   (refill_beat && last_beat),
    .fill_tag  (req_tag)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaulting every always_comb output first guarantees no path
    // leaves it unassigned, so no latch is inferred.
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (pend) begin
          if (req_write)  state_next = ST_WRITE_REQ;
          else if (!hit)  state_next = ST_REFILL_REQ;
        end
      end
      ST_REFILL_REQ:  if (mem_req_ready) state_next = ST_REFILL_DATA;
      ST_REFILL_DATA: if (mem_resp_valid && last_beat) state_next = ST_IDLE;
      ST_WRITE_REQ:   if (mem_req_ready) state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // Outputs. In IDLE stall comes straight from the tag compare; elsewhere it
  // follows the state register. Memory-port fields depend only on state and
  // the latched request, so they hold steady while waiting for ready.
  always_comb begin
    stall         = 1'b0;
    cpu_dout      = 32'h0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 30'h0;
    mem_req_data  = 32'h0;
    mem_req_mask  = 4'h0;
    unique case (state)
      ST_IDLE: begin
        stall    = pend && (req_write || !hit);
        cpu_dout = read_hit ? arr_data : 32'h0;
      end
      ST_REFILL_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_addr[29:OFF_W], {OFF_W{1'b0}}};
      end
      ST_REFILL_DATA: begin
        stall = 1'b1;
      end
      ST_WRITE_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = req_addr;
        mem_req_data  = req_data;
        mem_req_mask  = req_mask;
      end
      default: stall = 1'b1;
    endcase
  end

  // Request latch and refill beat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      req_mask  <= '0;
      beat_cnt  <= '0;
    end else begin
      // A new request can only be taken while stall is low, which includes
      // the read-hit cycle: the new request then replaces the finished one.
      if (accept) begin
        pend      <= 1'b1;
        req_write <= (cpu_we != 4'b0000);
        req_addr  <= cpu_addr[31:2];
        req_data  <= cpu_din;
        req_mask  <= cpu_we;
      end else if (read_hit) begin
        pend <= 1'b0;
      end else if ((state == ST_WRITE_REQ) && mem_req_ready) begin
        pend <= 1'b0;
      end

      if ((state == ST_REFILL_REQ) && mem_req_ready) begin
        beat_cnt <= '0;
      end else if (refill_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule
